// File: rtl/ab_xchg_pkg.sv
// Shared types for the a/b register-exchange engine.
package ab_xchg_pkg;

    localparam int OP_CNT_W = 16;

    typedef enum logic [1:0] {
        XCHG_HOLD    = 2'd0,
        XCHG_COPY_AB = 2'd1,
        XCHG_COPY_BA = 2'd2,
        XCHG_SWAP    = 2'd3
    } xchg_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } xchg_state_e;

endpackage

// File: rtl/ab_xchg_if.sv
// Register-fabric bus of the exchange engine: writes, command handshake, reads, status.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
interface ab_xchg_if
    import ab_xchg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
);
    logic                wr_en;
    logic                wr_sel;
    logic [CHW-1:0]      wr_ch;
    logic [WIDTH-1:0]    wr_data;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_mode;
    logic [NCH-1:0]      cmd_mask;
    logic                busy;
    logic                done;
    logic [CHW-1:0]      rd_ch;
    logic [WIDTH-1:0]    rd_a;
    logic [WIDTH-1:0]    rd_b;
    logic [OP_CNT_W-1:0] op_cnt;
    xchg_state_e         state;

    modport master (
        output wr_en, wr_sel, wr_ch, wr_data, cmd_valid, cmd_mode, cmd_mask, rd_ch,
        input  cmd_ready, busy, done, rd_a, rd_b, op_cnt, state
    );

    modport slave (
        input  wr_en, wr_sel, wr_ch, wr_data, cmd_valid, cmd_mode, cmd_mask, rd_ch,
        output cmd_ready, busy, done, rd_a, rd_b, op_cnt, state
    );
endinterface

// File: rtl/ab_xchg_prio_sel.sv
// Lowest-set-bit finder: index and one-hot of the lowest pending channel.
module ab_xchg_prio_sel #(
    parameter int NCH = 4,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] mask,
    output logic [CHW-1:0] idx,
    output logic [NCH-1:0] onehot
);
    // Two's-complement trick isolates the lowest set bit.
    assign onehot = mask & (~mask + 1'b1);

    always_comb begin
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) idx = CHW'(i);
        end
    end
endmodule

// File: rtl/ab_xchg_engine.sv
// Multi-channel a/b register exchange engine: applies a runtime transfer mode
// to each masked channel, lowest index first, one channel per clock.
module ab_xchg_engine
    import ab_xchg_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input logic     sysclk,
    input logic     rst,
    ab_xchg_if.slave bus
);
    logic [WIDTH-1:0]    a_q [NCH];
    logic [WIDTH-1:0]    b_q [NCH];
    xchg_state_e         state_q;
    xchg_mode_e          mode_q;
    logic [NCH-1:0]      pend_q;
    logic [OP_CNT_W-1:0] op_cnt_q;
    logic                ready_q, busy_q, done_q;

    logic [CHW-1:0]      sel_idx;
    logic [NCH-1:0]      sel_onehot;
    logic [NCH-1:0]      pend_next;
    logic                wr_hit;

    ab_xchg_prio_sel #(.NCH(NCH), .CHW(CHW)) u_prio (
        .mask   (pend_q),
        .idx    (sel_idx),
        .onehot (sel_onehot)
    );

    assign pend_next = pend_q & ~sel_onehot;

    // A write to the channel being processed this cycle loses to the engine.
    assign wr_hit = bus.wr_en && (32'(bus.wr_ch) < NCH) &&
                    !(state_q == ST_RUN && bus.wr_ch == sel_idx);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            state_q  <= ST_IDLE;
            mode_q   <= XCHG_HOLD;
            pend_q   <= '0;
            op_cnt_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (wr_hit) begin
                if (bus.wr_sel) b_q[bus.wr_ch] <= bus.wr_data;
                else            a_q[bus.wr_ch] <= bus.wr_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        mode_q  <= xchg_mode_e'(bus.cmd_mode);
                        pend_q  <= bus.cmd_mask;
                        ready_q <= 1'b0;
                        if (|bus.cmd_mask) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    case (mode_q)
                        XCHG_COPY_AB: b_q[sel_idx] <= a_q[sel_idx];
                        XCHG_COPY_BA: a_q[sel_idx] <= b_q[sel_idx];
                        XCHG_SWAP: begin
                            a_q[sel_idx] <= b_q[sel_idx];
                            b_q[sel_idx] <= a_q[sel_idx];
                        end
                        default: ;
                    endcase
                    if (mode_q != XCHG_HOLD && op_cnt_q != '1)
                        op_cnt_q <= op_cnt_q + 16'd1;
                    pend_q <= pend_next;
                    if (pend_next == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.op_cnt    = op_cnt_q;
    assign bus.state     = state_q;
    assign bus.rd_a      = (32'(bus.rd_ch) < NCH) ? a_q[bus.rd_ch] : '0;
    assign bus.rd_b      = (32'(bus.rd_ch) < NCH) ? b_q[bus.rd_ch] : '0;
endmodule

// File: tb/tb_ab_xchg_engine.sv
// Self-checking bench for ab_xchg_engine against a per-command channel-list model.
module tb_ab_xchg_engine;
  import ab_xchg_pkg::*;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int CW  = 2;
  localparam int SN  = 64;
  localparam int SCW = 6;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  logic srst   = 1'b1;

  always #5 sysclk = ~sysclk;

  ab_xchg_if #(.WIDTH(W), .NCH(N),  .CHW(CW))  m_if ();
  ab_xchg_if #(.WIDTH(W), .NCH(SN), .CHW(SCW)) s_if ();

  ab_xchg_engine #(.WIDTH(W), .NCH(N)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (m_if.slave)
  );

  ab_xchg_engine #(.WIDTH(W), .NCH(SN)) dut_sat (
    .sysclk (sysclk),
    .rst    (srst),
    .bus    (s_if.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ma [N];
  logic [W-1:0] mb [N];
  int unsigned  m_cnt;
  logic [W-1:0] exp_q [$];

  // ---------------- clock/reset helpers and drivers ----------------
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_inputs();
    m_if.wr_en = 0; m_if.wr_sel = 0; m_if.wr_ch = '0; m_if.wr_data = '0;
    m_if.cmd_valid = 0; m_if.cmd_mode = 2'd0; m_if.cmd_mask = '0; m_if.rd_ch = '0;
    s_if.wr_en = 0; s_if.wr_sel = 0; s_if.wr_ch = '0; s_if.wr_data = '0;
    s_if.cmd_valid = 0; s_if.cmd_mode = 2'd0; s_if.cmd_mask = '0; s_if.rd_ch = '0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      ma[c] = '0;
      mb[c] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic do_write(input logic sel, input int ch, input logic [W-1:0] d);
    m_if.wr_en = 1; m_if.wr_sel = sel; m_if.wr_ch = CW'(ch); m_if.wr_data = d;
    tick();
    m_if.wr_en = 0;
    if (sel) mb[ch] = d;
    else     ma[ch] = d;
  endtask

  // Reference: each masked channel in turn, mode applied to the pair.
  task automatic model_cmd(input logic [1:0] mode, input logic [N-1:0] mask);
    logic [W-1:0] t;
    for (int c = 0; c < N; c++) begin
      if (mask[c]) begin
        case (mode)
          2'd1: mb[c] = ma[c];
          2'd2: ma[c] = mb[c];
          2'd3: begin t = ma[c]; ma[c] = mb[c]; mb[c] = t; end
          default: ;
        endcase
        if (mode != 2'd0 && m_cnt < 32'hFFFF) m_cnt++;
      end
    end
  endtask

  // Issue a command from IDLE; report the cycle done appeared in and busy count.
  task automatic run_cmd(input logic [1:0] mode, input logic [N-1:0] mask,
                         output int done_cyc, output int busy_cyc);
    m_if.cmd_valid = 1; m_if.cmd_mode = mode; m_if.cmd_mask = mask;
    tick();
    m_if.cmd_valid = 0;
    done_cyc = -1;
    busy_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (m_if.busy) busy_cyc++;
      if (m_if.done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    tick();
    model_cmd(mode, mask);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++;
    if (m_if.cmd_ready !== 1'b1 || m_if.busy !== 1'b0 || m_if.done !== 1'b0 ||
        m_if.op_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_status ready=%b busy=%b done=%b op_cnt=%0d want 1 0 0 0",
               m_if.cmd_ready, m_if.busy, m_if.done, m_if.op_cnt);
    end
    for (int c = 0; c < N; c++) begin
      m_if.rd_ch = CW'(c);
      #1;
      checks++;
      if (m_if.rd_a !== 8'h00 || m_if.rd_b !== 8'h00) begin
        errors++;
        $display("FAIL reset_regs ch%0d a=%h b=%h want 00 00", c, m_if.rd_a, m_if.rd_b);
      end
    end
    rst = 0;
    model_clear();
    tick();
  endtask

  task automatic test_copy_sparse();
    int dc, bc;
    for (int c = 0; c < N; c++) begin
      do_write(1'b0, c, 8'h10 + 8'(c));
      do_write(1'b1, c, 8'hA0 + 8'(c));
    end
    run_cmd(2'd1, 4'b1010, dc, bc);
    checks++;
    if (dc !== 3 || bc !== 2) begin
      errors++;
      $display("FAIL copy_sparse_timing done_cycle=%0d busy_cycles=%0d want 3 2", dc, bc);
    end
    for (int c = 0; c < N; c++) begin
      m_if.rd_ch = CW'(c);
      #1;
      checks++;
      if (m_if.rd_a !== ma[c] || m_if.rd_b !== mb[c]) begin
        errors++;
        $display("FAIL copy_sparse_regs ch%0d a=%h b=%h want %h %h",
                 c, m_if.rd_a, m_if.rd_b, ma[c], mb[c]);
      end
    end
    checks++;
    if (m_if.op_cnt !== 16'd2 || mb[1] !== 8'h11 || mb[3] !== 8'h13 || mb[0] !== 8'hA0) begin
      errors++;
      $display("FAIL copy_sparse_cnt op_cnt=%0d want 2 (model b1=%h b3=%h b0=%h)",
               m_if.op_cnt, mb[1], mb[3], mb[0]);
    end
  endtask

  task automatic test_swap_full();
    int dc, bc;
    int unsigned cnt0;
    cnt0 = m_cnt;
    run_cmd(2'd3, 4'b1111, dc, bc);
    checks++;
    if (dc !== 5 || m_if.op_cnt !== 16'(cnt0 + 4)) begin
      errors++;
      $display("FAIL swap_full done_cycle=%0d op_cnt=%0d want 5 %0d", dc, m_if.op_cnt, cnt0 + 4);
    end
    for (int c = 0; c < N; c++) begin
      m_if.rd_ch = CW'(c);
      #1;
      checks++;
      if (m_if.rd_a !== ma[c] || m_if.rd_b !== mb[c]) begin
        errors++;
        $display("FAIL swap_full_regs ch%0d a=%h b=%h want %h %h",
                 c, m_if.rd_a, m_if.rd_b, ma[c], mb[c]);
      end
    end
    run_cmd(2'd0, 4'b1111, dc, bc);
    checks++;
    if (dc !== 5 || bc !== 4 || m_if.op_cnt !== 16'(cnt0 + 4)) begin
      errors++;
      $display("FAIL hold_full done_cycle=%0d busy=%0d op_cnt=%0d want 5 4 %0d",
               dc, bc, m_if.op_cnt, cnt0 + 4);
    end
    for (int c = 0; c < N; c++) begin
      m_if.rd_ch = CW'(c);
      #1;
      checks++;
      if (m_if.rd_a !== ma[c] || m_if.rd_b !== mb[c]) begin
        errors++;
        $display("FAIL hold_full_regs ch%0d a=%h b=%h want %h %h",
                 c, m_if.rd_a, m_if.rd_b, ma[c], mb[c]);
      end
    end
  endtask

  task automatic test_empty_backpressure();
    int dc, bc;
    int unsigned cnt0;
    logic r1, r2, r3, b4;
    cnt0 = m_cnt;
    run_cmd(2'd3, 4'b0000, dc, bc);
    checks++;
    if (dc !== 1 || bc !== 0 || m_if.op_cnt !== 16'(cnt0)) begin
      errors++;
      $display("FAIL empty_mask done_cycle=%0d busy=%0d op_cnt=%0d want 1 0 %0d",
               dc, bc, m_if.op_cnt, cnt0);
    end
    // cmd_valid held high: SWAP on ch0 accepted at edge 0 and again at edge 3.
    m_if.cmd_valid = 1; m_if.cmd_mode = 2'd3; m_if.cmd_mask = 4'b0001;
    tick();
    r1 = m_if.cmd_ready;
    tick();
    r2 = m_if.cmd_ready;
    tick();
    r3 = m_if.cmd_ready;
    tick();
    m_if.cmd_valid = 0;
    b4 = m_if.busy;
    checks++;
    if (r1 !== 1'b0 || r2 !== 1'b0 || r3 !== 1'b1 || b4 !== 1'b1) begin
      errors++;
      $display("FAIL backpressure ready c1=%b c2=%b c3=%b busy c4=%b want 0 0 1 1", r1, r2, r3, b4);
    end
    for (int c = 0; c < 10 && !m_if.done; c++) tick();
    tick();
    model_cmd(2'd3, 4'b0001);
    model_cmd(2'd3, 4'b0001);
    m_if.rd_ch = 2'd0;
    #1;
    checks++;
    if (m_if.rd_a !== ma[0] || m_if.rd_b !== mb[0] || m_if.op_cnt !== 16'(m_cnt) ||
        m_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_result a0=%h b0=%h op_cnt=%0d ready=%b want %h %h %0d 1",
               m_if.rd_a, m_if.rd_b, m_if.op_cnt, m_if.cmd_ready, ma[0], mb[0], m_cnt);
    end
  endtask

  task automatic test_collision();
    logic d_seen;
    do_write(1'b0, 1, 8'h21);
    do_write(1'b1, 1, 8'hB1);
    do_write(1'b0, 2, 8'h32);
    // COPY_BA on ch1, same-cycle write to a1 is dropped.
    m_if.cmd_valid = 1; m_if.cmd_mode = 2'd2; m_if.cmd_mask = 4'b0010;
    tick();
    m_if.cmd_valid = 0;
    m_if.wr_en = 1; m_if.wr_sel = 0; m_if.wr_ch = 2'd1; m_if.wr_data = 8'h55;
    tick();
    m_if.wr_en = 0;
    d_seen = m_if.done;
    tick();
    model_cmd(2'd2, 4'b0010);
    m_if.rd_ch = 2'd1;
    #1;
    checks++;
    if (d_seen !== 1'b1 || m_if.rd_a !== 8'hB1 || ma[1] !== 8'hB1) begin
      errors++;
      $display("FAIL collision_same_ch done=%b a1=%h want 1 b1", d_seen, m_if.rd_a);
    end
    // COPY_BA on ch1 again while writing a2: the other channel's write lands.
    m_if.cmd_valid = 1; m_if.cmd_mode = 2'd2; m_if.cmd_mask = 4'b0010;
    tick();
    m_if.cmd_valid = 0;
    m_if.wr_en = 1; m_if.wr_sel = 0; m_if.wr_ch = 2'd2; m_if.wr_data = 8'h66;
    tick();
    m_if.wr_en = 0;
    tick();
    model_cmd(2'd2, 4'b0010);
    ma[2] = 8'h66;
    m_if.rd_ch = 2'd2;
    #1;
    checks++;
    if (m_if.rd_a !== 8'h66 || m_if.rd_b !== mb[2]) begin
      errors++;
      $display("FAIL collision_other_ch a2=%h b2=%h want 66 %h", m_if.rd_a, m_if.rd_b, mb[2]);
    end
  endtask

  task automatic test_random();
    int dc, bc, k;
    logic [1:0] mode;
    logic [N-1:0] mask;
    for (int it = 0; it < 24; it++) begin
      for (int w = 0; w < 3; w++)
        do_write(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), 8'($urandom_range(0, 255)));
      mode = 2'($urandom_range(0, 3));
      mask = 4'($urandom_range(0, 15));
      k = $countones(mask);
      run_cmd(mode, mask, dc, bc);
      checks++;
      if (dc !== k + 1 || bc !== k || m_if.op_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random_cmd it%0d mode=%0d mask=%b done=%0d busy=%0d op_cnt=%0d want %0d %0d %0d",
                 it, mode, mask, dc, bc, m_if.op_cnt, k + 1, k, m_cnt);
      end
      for (int c = 0; c < N; c++) begin
        exp_q.push_back(ma[c]);
        exp_q.push_back(mb[c]);
      end
      for (int c = 0; c < N; c++) begin
        logic [W-1:0] ea, eb;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        m_if.rd_ch = CW'(c);
        #1;
        checks++;
        if (m_if.rd_a !== ea || m_if.rd_b !== eb) begin
          errors++;
          $display("FAIL random_regs it%0d ch%0d a=%h b=%h want %h %h",
                   it, c, m_if.rd_a, m_if.rd_b, ea, eb);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic d_seen;
    for (int c = 0; c < N; c++) do_write(1'b0, c, 8'hC0 + 8'(c));
    m_if.cmd_valid = 1; m_if.cmd_mode = 2'd3; m_if.cmd_mask = 4'b1111;
    tick();
    m_if.cmd_valid = 0;
    tick();
    // Mid-RUN reset with a write and a command offered at the same time.
    rst = 1;
    m_if.wr_en = 1; m_if.wr_sel = 1; m_if.wr_ch = 2'd0; m_if.wr_data = 8'hFF;
    m_if.cmd_valid = 1; m_if.cmd_mask = 4'b1111;
    tick();
    d_seen = m_if.done;
    checks++;
    if (m_if.busy !== 1'b0 || m_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_status busy=%b ready=%b want 0 1", m_if.busy, m_if.cmd_ready);
    end
    rst = 0;
    m_if.wr_en = 0;
    m_if.cmd_valid = 0;
    for (int c = 0; c < 6; c++) begin
      if (m_if.done) d_seen = 1'b1;
      tick();
    end
    model_clear();
    checks++;
    if (d_seen !== 1'b0 || m_if.op_cnt !== 16'd0) begin
      errors++;
      $display("FAIL abort_done done_seen=%b op_cnt=%0d want 0 0", d_seen, m_if.op_cnt);
    end
    for (int c = 0; c < N; c++) begin
      m_if.rd_ch = CW'(c);
      #1;
      checks++;
      if (m_if.rd_a !== 8'h00 || m_if.rd_b !== 8'h00) begin
        errors++;
        $display("FAIL abort_regs ch%0d a=%h b=%h want 00 00", c, m_if.rd_a, m_if.rd_b);
      end
    end
  endtask

  task automatic test_saturation();
    int unsigned s_cnt;
    int dc;
    s_cnt = 0;
    srst = 0;
    tick();
    checks++;
    if (s_if.op_cnt !== 16'd0 || s_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_reset op_cnt=%0d ready=%b want 0 1", s_if.op_cnt, s_if.cmd_ready);
    end
    for (int n = 1; n <= 1025; n++) begin
      s_if.cmd_valid = 1; s_if.cmd_mode = 2'd3; s_if.cmd_mask = '1;
      tick();
      s_if.cmd_valid = 0;
      dc = -1;
      for (int c = 1; c <= 100; c++) begin
        if (s_if.done) begin
          dc = c;
          break;
        end
        tick();
      end
      tick();
      s_cnt = (s_cnt + SN > 32'hFFFF) ? 32'hFFFF : s_cnt + SN;
      if (dc < 0) begin
        checks++;
        errors++;
        $display("FAIL sat_timeout cmd%0d no done within 100 cycles", n);
        break;
      end
      if (n == 1) begin
        checks++;
        if (dc !== SN + 1) begin
          errors++;
          $display("FAIL sat_first_done done_cycle=%0d want %0d", dc, SN + 1);
        end
      end
      if (n == 1 || n == 1023 || n == 1024 || n == 1025) begin
        checks++;
        if (s_if.op_cnt !== 16'(s_cnt)) begin
          errors++;
          $display("FAIL sat_cnt cmd%0d op_cnt=%0d want %0d", n, s_if.op_cnt, s_cnt);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_copy_sparse();
    test_swap_full();
    test_empty_backpressure();
    test_collision();
    test_random();
    test_abort();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ab_xchg_engine.md
# ab_xchg_engine

Parametrised multi-channel register-exchange engine. It holds NCH pairs of WIDTH-bit registers (a, b). On a command it applies one of four runtime-selected transfer modes (hold, copy a→b, copy b→a, swap) to every channel in a mask, one channel per clock. It sits on the CPU-side register fabric next to the chip-level mode logic, and replaces compile-time selection of the transfer direction with runtime selection.

## Interface
- WIDTH, 8, data width of each a/b register
- NCH, 4, number of channels (≥1)
- CHW, $clog2(NCH) (min 1), derived channel-index width; not overridden
- sysclk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  register write strobe
- wr_sel  in  1  0 = write a, 1 = write b
- wr_ch  in  CHW  write channel index
- wr_data  in  WIDTH  write data
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid && ready
- cmd_mode  in  2  0 HOLD, 1 COPY_AB (b←a), 2 COPY_BA (a←b), 3 SWAP
- cmd_mask  in  NCH  channels to process
- busy  out  1  engine executing a command
- done  out  1  one-cycle completion pulse
- rd_ch  in  CHW  read channel index
- rd_a, rd_b  out  WIDTH  combinational read of the selected channel's a/b
- op_cnt  out  16  saturating count of non-HOLD channel operations

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: cmd_ready=1. On handshake, latch mode and mask into a pending mask. Go to RUN if the mask is non-zero, else go to DONE.
- RUN: each cycle, select the lowest set bit of the pending mask. Apply the mode to that channel at the cycle's ending edge and clear the bit. When the bit cleared was the last one, go to DONE.
- SWAP updates a and b on the same edge using the old values.
- HOLD consumes one RUN cycle per masked channel. It changes no data and does not count.
- DONE: done=1 for exactly one cycle, then go to IDLE. cmd_ready=0 in RUN and DONE. busy=1 in RUN only.
- Writes are accepted in every state.
- If a write targets the channel being processed in the same cycle, the engine operation wins and the write is dropped. Writes to other channels take effect normally.
- With wr_sel=0 the write updates a only; with wr_sel=1, b only.
- Out-of-range wr_ch (≥NCH) is ignored. Out-of-range rd_ch returns 0.
- op_cnt increments by 1 per COPY_AB/COPY_BA/SWAP channel operation and saturates at 16'hFFFF.

## Timing
- Handshake at edge 0 with k set mask bits: RUN occupies cycles 1..k, and done is high in cycle k+1. The next command is accepted no earlier than edge k+2.
- Empty mask: done is high in cycle 1 with no data change.
- rd_a/rd_b reflect register updates in the cycle after the edge that performed them.
- Reset values: all a/b = 0, state IDLE, cmd_ready=1, busy=0, done=0, op_cnt=0, rd_a/rd_b=0.
- Reset during RUN/DONE aborts the command: no done pulse, and registers are cleared. Reset has priority over writes and over command acceptance.

## Structure
- Package ab_xchg_pkg holds:
  - mode enum xchg_mode_e (XCHG_HOLD, XCHG_COPY_AB, XCHG_COPY_BA, XCHG_SWAP)
  - state enum xchg_state_e
  - OP_CNT_W = 16
- Sub-module ab_xchg_prio_sel: a combinational lowest-set-bit finder. It takes the NCH-bit mask and outputs the index (CHW bits) and a one-hot vector. It is reused for mask clearing.

## Test plan
- **Reset:** rst for 2 cycles → all outputs at reset values; cmd_ready=1.
- **Copy with sparse mask:** WIDTH=8, NCH=4, load a[ch]=8'h10+ch and b[ch]=8'hA0+ch; COPY_AB with mask 4'b1010 → channels 1 and 3 processed in cycles 1 and 2, done in cycle 3; b1=8'h11, b3=8'h13, b0=8'hA0, b2=8'hA2 unchanged; op_cnt=2.
- **Swap full mask:** SWAP with mask 4'b1111 → a/b exchanged on all channels, done in cycle 5; op_cnt increases by 4; HOLD with the same mask → done in cycle 5, no data change, op_cnt unchanged.
- **Empty mask and back-pressure:** mask 0 → done in cycle 1, no changes; cmd_valid held high through RUN/DONE → not re-accepted until IDLE.
- **Write collision:** during RUN on ch1 (COPY_BA), write a1=8'h55 in the same cycle → a1 equals old b1. A write to ch2 in the same cycle lands.
- **Abort and saturation:** rst asserted mid-RUN → no done pulse, registers and op_cnt = 0. Preload op_cnt near 16'hFFFF via repeated SWAPs → holds at 16'hFFFF.
